// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration sequencer.
//   A_TX_*      : host-side register bus addresses of the SPI master
//   A_T_*_WAIT  : slave register indices for the traffic-light timers
//   CMD_WRITE   : command byte that selects a register write on the slave
//   state_e     : sequencer state encoding
package spi_cfg_pkg;

  localparam logic [7:0] A_TX_START = 8'h00;
  localparam logic [7:0] A_TX_CMD   = 8'h01;
  localparam logic [7:0] A_TX_ADDR  = 8'h02;
  localparam logic [7:0] A_TX_DATA  = 8'h03;

  localparam logic [1:0] A_T_R_WAIT = 2'h0;
  localparam logic [1:0] A_T_G_WAIT = 2'h1;

  localparam logic [7:0] CMD_WRITE  = 8'h01;

  typedef enum logic [2:0] {
    StBootChk,
    StIdle,
    StCmd,
    StAddr,
    StData,
    StStartHi,
    StStartLo,
    StGap
  } state_e;

endpackage

// File: rtl/spi_cfg_seq.sv
// Configuration sequencer for the SPI master's host register bus.
// After reset it optionally writes the two boot timer values, then serves single-register
// write requests. Each write is the fixed bus sequence CMD, ADDR, DATA, START high for
// START_HOLD cycles, START low for one cycle, then XFER_WAIT idle cycles for the frame.
//
// Ports:
//   clk, n_rst          : sequencer clock (master clock) and async active-low reset
//   req_valid/req_ready : write request handshake
//   req_addr, req_data  : target register index and value, latched on acceptance
//   m_addr, m_wen,
//   m_data              : master host-side register bus
//   busy                : boot or user sequence in progress
//   done                : one-cycle pulse on the last idle cycle of a user write
//   boot_done           : sticky, boot writes finished (or boot disabled)
module spi_cfg_seq
  import spi_cfg_pkg::*;
#(
  parameter int unsigned START_HOLD  = 2,
  parameter int unsigned XFER_WAIT   = 32,
  parameter bit          BOOT_EN     = 1'b1,
  parameter logic [2:0]  BOOT_R_WAIT = 3'h2,
  parameter logic [2:0]  BOOT_G_WAIT = 3'h5
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_addr,
  input  logic [2:0] req_data,
  output logic [7:0] m_addr,
  output logic       m_wen,
  output logic [7:0] m_data,
  output logic       busy,
  output logic       done,
  output logic       boot_done
);

  localparam int unsigned MaxCnt = (START_HOLD > XFER_WAIT) ? START_HOLD : XFER_WAIT;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] HoldLoad = CntW'(START_HOLD - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'(XFER_WAIT - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;       // shared by START_HI and GAP
  logic            boot_idx_q;  // 0: t_r_wait boot write, 1: t_g_wait boot write
  logic            in_boot_q;   // current sequence is a boot write (no done pulse)
  logic [1:0]      addr_q;
  logic [2:0]      data_q;
  logic            last_gap;

  // High on the edge that enters the final GAP cycle, so done/boot_done line up with it.
  always_comb begin
    last_gap = 1'b0;
    if (state_q == StStartLo) begin
      last_gap = (XFER_WAIT == 1);
    end else if (state_q == StGap) begin
      last_gap = (cnt_q == CntOne);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StBootChk;
      cnt_q      <= '0;
      boot_idx_q <= 1'b0;
      in_boot_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      m_addr     <= A_TX_CMD;
      m_wen      <= 1'b0;
      m_data     <= 8'h00;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      boot_done  <= 1'b0;
    end else begin
      done <= 1'b0;

      unique case (state_q)
        StBootChk: begin
          if (BOOT_EN) begin
            in_boot_q  <= 1'b1;
            boot_idx_q <= 1'b0;
            addr_q     <= A_T_R_WAIT;
            data_q     <= BOOT_R_WAIT;
            state_q    <= StCmd;
            m_addr     <= A_TX_CMD;
            m_wen      <= 1'b1;
            m_data     <= CMD_WRITE;
            busy       <= 1'b1;
          end else begin
            state_q   <= StIdle;
            boot_done <= 1'b1;
            req_ready <= 1'b1;
          end
        end

        StIdle: begin
          if (req_valid && req_ready) begin
            in_boot_q <= 1'b0;
            addr_q    <= req_addr;
            data_q    <= req_data;
            state_q   <= StCmd;
            m_addr    <= A_TX_CMD;
            m_wen     <= 1'b1;
            m_data    <= CMD_WRITE;
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end
        end

        StCmd: begin
          state_q <= StAddr;
          m_addr  <= A_TX_ADDR;
          m_data  <= {6'h00, addr_q};
        end

        StAddr: begin
          state_q <= StData;
          m_addr  <= A_TX_DATA;
          m_data  <= {5'h00, data_q};
        end

        StData: begin
          state_q <= StStartHi;
          m_addr  <= A_TX_START;
          m_data  <= 8'h01;
          cnt_q   <= HoldLoad;
        end

        StStartHi: begin
          if (cnt_q == '0) begin
            state_q <= StStartLo;
            m_data  <= 8'h00;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end

        StStartLo: begin
          state_q <= StGap;
          m_wen   <= 1'b0;
          m_addr  <= A_TX_CMD;
          m_data  <= 8'h00;
          cnt_q   <= GapLoad;
        end

        StGap: begin
          if (cnt_q == '0) begin
            if (in_boot_q && !boot_idx_q) begin
              // Second boot write follows the first with no idle cycle in between.
              boot_idx_q <= 1'b1;
              addr_q     <= A_T_G_WAIT;
              data_q     <= BOOT_G_WAIT;
              state_q    <= StCmd;
              m_addr     <= A_TX_CMD;
              m_wen      <= 1'b1;
              m_data     <= CMD_WRITE;
            end else begin
              in_boot_q <= 1'b0;
              state_q   <= StIdle;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
      endcase

      if (last_gap) begin
        if (in_boot_q) begin
          if (boot_idx_q) begin
            boot_done <= 1'b1;
          end
        end else begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule
